// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction at a time walks IDLE -> ISSUE -> WAIT -> DONE, with a bounded wait on mem_busy.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        m0_req,
  input  logic [31:0] m0_address,
  input  logic [31:0] m0_data_in,
  input  logic        m0_read_write,
  input  logic        m0_access_size,
  input  logic        m0_byte_s,
  output logic        m0_grant,
  output logic        m0_done,
  output logic [31:0] m0_rdata,

  input  logic        m1_req,
  input  logic [31:0] m1_address,
  input  logic [31:0] m1_data_in,
  input  logic        m1_read_write,
  input  logic        m1_access_size,
  input  logic        m1_byte_s,
  output logic        m1_grant,
  output logic        m1_done,
  output logic [31:0] m1_rdata,

  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  output logic        mem_enable,
  output logic        mem_access_size,
  output logic        mem_byte_s,
  input  logic [31:0] mem_data_out,
  input  logic        mem_busy,

  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_e      state_q;
  logic        last_owner_q;
  logic        owner_q;
  logic [7:0]  wait_cnt_q;
  logic [7:0]  wait_cnt_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        rw_q;
  logic        size_q;
  logic        byte_s_q;
  logic        mem_en_q;
  logic [1:0]  grant_q;
  logic [1:0]  done_q;
  logic [31:0] rdata0_q;
  logic [31:0] rdata1_q;
  logic        timeout_q;

  logic        any_req;
  logic        owner_d;

  always_comb begin
    any_req    = m0_req | m1_req;
    // On a tie the requester that did not go last wins; otherwise whoever asks.
    owner_d    = (m0_req && m1_req) ? ~last_owner_q : m1_req;
    wait_cnt_d = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
      state_q      <= S_IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rw_q         <= 1'b0;
      size_q       <= 1'b0;
      byte_s_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      grant_q      <= '0;
      done_q       <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
      timeout_q    <= 1'b0;
    end else begin
      done_q <= '0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            owner_q      <= owner_d;
            last_owner_q <= owner_d;
            grant_q      <= owner_d ? 2'b10 : 2'b01;
            addr_q       <= owner_d ? m1_address     : m0_address;
            wdata_q      <= owner_d ? m1_data_in     : m0_data_in;
            rw_q         <= owner_d ? m1_read_write  : m0_read_write;
            size_q       <= owner_d ? m1_access_size : m0_access_size;
            byte_s_q     <= owner_d ? m1_byte_s      : m0_byte_s;
            wait_cnt_q   <= '0;
            mem_en_q     <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: state_q <= S_WAIT;
        S_WAIT: begin
          if (!mem_busy) begin
            if (!rw_q) begin
              if (owner_q) rdata1_q <= mem_data_out;
              else         rdata0_q <= mem_data_out;
            end
            mem_en_q <= 1'b0;
            done_q   <= grant_q;
            state_q  <= S_DONE;
          end else if (wait_cnt_d == TIMEOUT_LIM) begin
            // Abort: the owner sees zero data and the sticky error flag.
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= 1'b1;
            if (owner_q) rdata1_q <= '0;
            else         rdata0_q <= '0;
            mem_en_q   <= 1'b0;
            done_q     <= grant_q;
            state_q    <= S_DONE;
          end else begin
            wait_cnt_q <= wait_cnt_d;
          end
        end
        S_DONE: begin
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m0_grant        = grant_q[0];
  assign m1_grant        = grant_q[1];
  assign m0_done         = done_q[0];
  assign m1_done         = done_q[1];
  assign m0_rdata        = rdata0_q;
  assign m1_rdata        = rdata1_q;
  assign mem_address     = addr_q;
  assign mem_data_in     = wdata_q;
  assign mem_read_write  = rw_q;
  assign mem_enable      = mem_en_q;
  assign mem_access_size = size_q;
  assign mem_byte_s      = byte_s_q;
  assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a default instance plus a TIMEOUT_CYCLES=4 instance
// sharing the same stimulus.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_address, m0_data_in, m1_address, m1_data_in;
  logic        m0_read_write, m0_access_size, m0_byte_s;
  logic        m1_read_write, m1_access_size, m1_byte_s;
  logic [31:0] mem_data_out;
  logic        mem_busy;

  logic        m0_grant, m0_done, m1_grant, m1_done;
  logic [31:0] m0_rdata, m1_rdata, mem_address, mem_data_in;
  logic        mem_read_write, mem_enable, mem_access_size, mem_byte_s, timeout_err;

  logic        m0_grant_b, m0_done_b, m1_grant_b, m1_done_b;
  logic [31:0] m0_rdata_b, m1_rdata_b, mem_address_b, mem_data_in_b;
  logic        mem_read_write_b, mem_enable_b, mem_access_size_b, mem_byte_s_b, timeout_err_b;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dmem_arbiter dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_address(m0_address), .m0_data_in(m0_data_in),
    .m0_read_write(m0_read_write), .m0_access_size(m0_access_size), .m0_byte_s(m0_byte_s),
    .m0_grant(m0_grant), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_address(m1_address), .m1_data_in(m1_data_in),
    .m1_read_write(m1_read_write), .m1_access_size(m1_access_size), .m1_byte_s(m1_byte_s),
    .m1_grant(m1_grant), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
    .mem_enable(mem_enable), .mem_access_size(mem_access_size), .mem_byte_s(mem_byte_s),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy), .timeout_err(timeout_err)
  );

  dmem_arbiter #(.TIMEOUT_CYCLES(4)) dut_to (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_address(m0_address), .m0_data_in(m0_data_in),
    .m0_read_write(m0_read_write), .m0_access_size(m0_access_size), .m0_byte_s(m0_byte_s),
    .m0_grant(m0_grant_b), .m0_done(m0_done_b), .m0_rdata(m0_rdata_b),
    .m1_req(m1_req), .m1_address(m1_address), .m1_data_in(m1_data_in),
    .m1_read_write(m1_read_write), .m1_access_size(m1_access_size), .m1_byte_s(m1_byte_s),
    .m1_grant(m1_grant_b), .m1_done(m1_done_b), .m1_rdata(m1_rdata_b),
    .mem_address(mem_address_b), .mem_data_in(mem_data_in_b), .mem_read_write(mem_read_write_b),
    .mem_enable(mem_enable_b), .mem_access_size(mem_access_size_b), .mem_byte_s(mem_byte_s_b),
    .mem_data_out(mem_data_out), .mem_busy(mem_busy), .timeout_err(timeout_err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int en_cnt;
    int done_at;
    int done_cnt;
    int done_seen;

    reset = 1'b1;
    m0_req = 0; m1_req = 0;
    m0_address = '0; m0_data_in = '0; m0_read_write = 0; m0_access_size = 0; m0_byte_s = 0;
    m1_address = '0; m1_data_in = '0; m1_read_write = 0; m1_access_size = 0; m1_byte_s = 0;
    mem_data_out = '0; mem_busy = 0;

    // Reset state
    do_reset();
    check("rst_m0_grant", 32'(m0_grant), 32'd0);
    check("rst_m1_grant", 32'(m1_grant), 32'd0);
    check("rst_mem_enable", 32'(mem_enable), 32'd0);
    check("rst_mem_address", mem_address, 32'h0);
    check("rst_m0_rdata", m0_rdata, 32'h0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);

    // Single read by m0
    m0_address = 32'h10; m0_read_write = 0; m0_access_size = 1;
    mem_data_out = 32'hDEADBEEF; mem_busy = 0;
    m0_req = 1;
    tick();
    check("rd_issue_m0_grant", 32'(m0_grant), 32'd1);
    check("rd_issue_m1_grant", 32'(m1_grant), 32'd0);
    check("rd_issue_mem_enable", 32'(mem_enable), 32'd1);
    check("rd_issue_mem_address", mem_address, 32'h10);
    check("rd_issue_mem_size", 32'(mem_access_size), 32'd1);
    tick();
    check("rd_wait_m0_done", 32'(m0_done), 32'd0);
    check("rd_wait_mem_enable", 32'(mem_enable), 32'd1);
    tick();
    check("rd_done_m0_done", 32'(m0_done), 32'd1);
    check("rd_done_m0_rdata", m0_rdata, 32'hDEADBEEF);
    check("rd_done_m1_done", 32'(m1_done), 32'd0);
    check("rd_done_m1_rdata", m1_rdata, 32'h0);
    check("rd_done_mem_enable", 32'(mem_enable), 32'd0);
    m0_req = 0;
    tick();
    check("rd_idle_m0_done", 32'(m0_done), 32'd0);
    check("rd_idle_m0_grant", 32'(m0_grant), 32'd0);

    // Field hold: requester address changes during WAIT
    mem_busy = 1; m0_req = 1;
    tick();
    tick();
    m0_address = 32'h20;
    tick();
    check("hold_wait_mem_address", mem_address, 32'h10);
    mem_busy = 0;
    tick();
    check("hold_done_m0_done", 32'(m0_done), 32'd1);
    check("hold_done_mem_address", mem_address, 32'h10);
    m0_req = 0;
    tick();

    // Tie after reset, then alternation while both keep requesting
    do_reset();
    m0_address = 32'h100; m1_address = 32'h200;
    m0_read_write = 0; m1_read_write = 0;
    m0_req = 1; m1_req = 1;
    for (int i = 0; i < 4; i++) begin
      mem_data_out = 32'h1111_0000 + 32'(i);
      tick();
      check("tie_m0_grant", 32'(m0_grant), 32'((i % 2) == 0));
      check("tie_m1_grant", 32'(m1_grant), 32'((i % 2) == 1));
      check("tie_mem_address", mem_address, ((i % 2) == 1) ? 32'h200 : 32'h100);
      tick();
      tick();
      check("tie_m0_done", 32'(m0_done), 32'((i % 2) == 0));
      check("tie_m1_done", 32'(m1_done), 32'((i % 2) == 1));
      check("tie_rdata", ((i % 2) == 1) ? m1_rdata : m0_rdata, 32'h1111_0000 + 32'(i));
      tick();
      check("tie_idle_grants", 32'({m1_grant, m0_grant}), 32'd0);
    end
    m0_req = 0; m1_req = 0;

    // Busy stretch: m1 store, busy for 5 WAIT cycles
    m1_address = 32'h300; m1_data_in = 32'hCAFEF00D; m1_read_write = 1;
    mem_data_out = 32'h9999_9999; mem_busy = 1;
    m1_req = 1;
    en_cnt = 0; done_at = -1; done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (c == 0) begin
        check("st_issue_mem_data_in", mem_data_in, 32'hCAFEF00D);
        check("st_issue_mem_rw", 32'(mem_read_write), 32'd1);
        check("st_issue_m1_grant", 32'(m1_grant), 32'd1);
      end
      if (mem_enable) en_cnt++;
      if (m1_done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
        m1_req = 0;
      end
      if (c == 6) mem_busy = 0;
    end
    check("st_enable_cycles", 32'(en_cnt), 32'd7);
    check("st_done_cycle", 32'(done_at), 32'd7);
    check("st_done_pulses", 32'(done_cnt), 32'd1);
    check("st_m1_rdata_kept", m1_rdata, 32'h1111_0003);
    check("st_m0_rdata_kept", m0_rdata, 32'h1111_0002);
    check("st_no_timeout", 32'(timeout_err), 32'd0);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    do_reset();
    m0_address = 32'h40; m0_read_write = 0;
    mem_data_out = 32'h5555_AAAA; mem_busy = 0;
    m0_req = 1;
    tick(); tick(); tick();
    check("to_pre_rdata", m0_rdata_b, 32'h5555_AAAA);
    m0_req = 0;
    tick();
    mem_busy = 1; m0_req = 1;
    done_at = -1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m0_done_b) begin
        done_at = c;
        break;
      end
    end
    check("to_done_cycle", 32'(done_at), 32'd5);
    check("to_timeout_err", 32'(timeout_err_b), 32'd1);
    check("to_m0_rdata", m0_rdata_b, 32'h0);
    check("to_done_grant", 32'(m0_grant_b), 32'd1);
    m0_req = 0;
    tick();
    check("to_idle_done", 32'(m0_done_b), 32'd0);
    check("to_idle_grant", 32'(m0_grant_b), 32'd0);
    check("to_idle_mem_enable", 32'(mem_enable_b), 32'd0);
    check("to_err_sticky", 32'(timeout_err_b), 32'd1);
    check("to_default_no_err", 32'(timeout_err), 32'd0);
    check("to_default_still_wait", 32'(mem_enable), 32'd1);

    // Reset while the default instance is in WAIT for m0
    check("rw_pre_m0_grant", 32'(m0_grant), 32'd1);
    reset = 1'b1;
    tick();
    check("rw_m0_grant", 32'(m0_grant), 32'd0);
    check("rw_m1_grant", 32'(m1_grant), 32'd0);
    check("rw_m0_done", 32'(m0_done), 32'd0);
    check("rw_mem_enable", 32'(mem_enable), 32'd0);
    check("rw_mem_address", mem_address, 32'h0);
    check("rw_mem_data_in", mem_data_in, 32'h0);
    check("rw_m0_rdata", m0_rdata, 32'h0);
    check("rw_err_cleared", 32'(timeout_err_b), 32'd0);
    reset = 1'b0; mem_busy = 0;
    done_seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (m0_done) done_seen++;
    end
    check("rw_no_done", 32'(done_seen), 32'd0);
    m0_address = 32'h500; m1_address = 32'h600;
    m0_req = 1; m1_req = 1;
    tick();
    check("rw_tie_m0_grant", 32'(m0_grant), 32'd1);
    check("rw_tie_m1_grant", 32'(m1_grant), 32'd0);
    check("rw_tie_mem_address", mem_address, 32'h500);
    m0_req = 0; m1_req = 0;
    tick(); tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
